instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the control FSM. It holds the program counter and requests instruction words from program memory over a req/ack handshake. It latches each word into an instruction register and presents its 3-bit OPCODE and operand field to the FSM under a valid/taken handshake. Branch redirection is applied when the FSM takes an instruction.

## Interface
Parameters:
- ADDR_W, 8, program-counter and memory-address width
- INSTR_W, 16, instruction word width; OPCODE = bits [INSTR_W-1:INSTR_W-3], operand = bits [INSTR_W-4:0]
- PC_RESET, 0, PC value loaded by Clear

Ports:
- Clock  in  1  single clock; all state changes on rising edge
- Clear  in  1  reset, asynchronous, active-high
- MemReq  out  1  fetch request to program memory
- MemAddr  out  ADDR_W  fetch address; stable while MemReq=1
- MemAck  in  1  memory has MemData valid this cycle
- MemData  in  INSTR_W  instruction word
- OPCODE  out  3  opcode of held instruction (to FSM)
- Operand  out  INSTR_W-3  operand field of held instruction
- InstrValid  out  1  OPCODE/Operand hold a valid instruction
- InstrTaken  in  1  FSM consumes instruction (effective only when InstrValid=1)
- Branch  in  1  redirect PC; sampled only with an effective InstrTaken
- BranchTarget  in  ADDR_W  redirect address
- PC  out  ADDR_W  address of next word to fetch

## Operation
- States: IDLE, FETCH, HOLD; FLUSH exists only with the prefetch option enabled.
- Reset state and output values: IDLE; MemReq=0, MemAddr=PC_RESET, PC=PC_RESET, OPCODE=000, Operand=0, InstrValid=0.
- IDLE -> FETCH on the first rising edge with Clear=0.
- FETCH:
  - MemReq=1, MemAddr=PC.
  - On an edge with MemAck=1: capture MemData into the IR, PC <= PC+1 modulo 2^ADDR_W, go to HOLD.
- HOLD:
  - InstrValid=1 and MemReq=0.
  - On an edge with InstrTaken=1 and Branch=0: go to FETCH.
  - On an edge with InstrTaken=1 and Branch=1: PC <= BranchTarget, go to FETCH.
- Branch without InstrTaken is ignored.
- MemAck while MemReq=0 is ignored.
- PC wrap: 2^ADDR_W-1 increments to 0, with no flag.
- Clear mid-fetch: MemReq drops asynchronously and any in-flight word is abandoned. Memory must tolerate an abandoned request.

## Timing
- All outputs are registered, except that Clear forces the reset values immediately.
- MemReq asserts the cycle after entering FETCH and stays high until the edge that samples MemAck=1.
- Fetch-to-valid latency: InstrValid rises the cycle after the MemAck edge.
- Base throughput with zero-wait memory and immediate InstrTaken: 1 instruction per 2 cycles.
- Redirect: the first MemAddr after a branch equals BranchTarget, in the cycle following the taken edge.

## Configuration
- FETCH_PREFETCH_EN defined: adds a one-entry prefetch buffer.
  - In HOLD, MemReq is reasserted for PC while InstrValid stays high.
  - An acked word fills the buffer, and PC increments.
  - On InstrTaken with the buffer full and no branch, the buffer moves to the IR on the same edge. InstrValid stays high, so throughput is 1 instruction/cycle.
  - Taken with the buffer empty and a request outstanding: the unit stays in FETCH and the word loads directly into the IR on ack.
  - Branch flushes the buffer. If a request is outstanding, the unit enters FLUSH, holds MemReq until MemAck, discards that word, then fetches BranchTarget.
- FETCH_PREFETCH_EN undefined: no buffer and no FLUSH state; behaviour exactly as in Operation.

## Structure
- Shared package cpu_pkg holds:
  - opcode_t, a 3-bit enum shared with the FSM
  - fetch_state_t enum
  - OPCODE_W=3
- Natural sub-module: fetch_pc. It contains the PC register, the increment/wrap logic and the branch-load mux, with load/inc/target inputs.
- The rest, FSM and IR/buffer, stays in instr_fetch_unit.

## Test plan
- Reset: Clear=1 mid-FETCH with MemReq=1 -> MemReq=0 and InstrValid=0 asynchronously; after release, first MemAddr=PC_RESET=0x00.
- Sequential fetch, zero-wait memory, InstrTaken tied to 1: memory words 0x2001, 0x4002 -> OPCODE 001 then 010, Operand 0x0001 then 0x0002, MemAddr 0x00, 0x01.
- Backpressure: InstrTaken=0 for 5 cycles in HOLD -> OPCODE/Operand stable, MemReq=0 (no prefetch), PC unchanged.
- Branch: Branch=1, BranchTarget=0x40 with InstrTaken -> next MemAddr=0x40, and PC=0x41 after ack. Branch=1 without InstrTaken -> ignored.
- Wrap and wait states: PC=0xFF, MemAck delayed 3 cycles -> MemAddr held at 0xFF throughout, then PC=0x00.
- FETCH_PREFETCH_EN: zero-wait memory -> InstrValid continuously high, one instruction per cycle. Branch with a prefetch outstanding -> the acked word is discarded and the next IR content comes from BranchTarget.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types shared by the fetch unit and the control FSM.
// ST_FLUSH exists only when FETCH_PREFETCH_EN is defined.
package cpu_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_AND   = 3'd5,
        OP_JMP   = 3'd6,
        OP_HALT  = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
`ifdef FETCH_PREFETCH_EN
        , ST_FLUSH = 2'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: branch load has priority over increment; increment wraps
// silently modulo 2^ADDR_W.
module fetch_pc
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}}
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // PC register with branch-load and wrap-around increment
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_pc <= PC_RESET;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory req/ack, instruction register and
// valid/taken handoff to the FSM. FETCH_PREFETCH_EN adds a one-entry prefetch buffer.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}}
) (
    input  logic                  Clock,
    input  logic                  Clear,
    output logic                  MemReq,
    output logic [ADDR_W-1:0]     MemAddr,
    input  logic                  MemAck,
    input  logic [INSTR_W-1:0]    MemData,
    output logic [OPCODE_W-1:0]   OPCODE,
    output logic [INSTR_W-4:0]    Operand,
    output logic                  InstrValid,
    input  logic                  InstrTaken,
    input  logic                  Branch,
    input  logic [ADDR_W-1:0]     BranchTarget,
    output logic [ADDR_W-1:0]     PC
);

    fetch_state_t        r_state, w_state_nx;
    logic                r_mem_req, w_mem_req_nx;
    logic [INSTR_W-1:0]  r_ir, w_ir_nx;
    logic                r_valid, w_valid_nx;
    logic                w_pc_load, w_pc_inc;
    logic [ADDR_W-1:0]   w_pc_target, w_pc;
    logic                w_ack, w_taken;
`ifdef FETCH_PREFETCH_EN
    logic [INSTR_W-1:0]  r_buf, w_buf_nx;
    logic                r_buf_valid, w_buf_valid_nx;
    logic [ADDR_W-1:0]   r_tgt, w_tgt_nx;
`endif

    assign w_ack   = MemAck & r_mem_req;
    assign w_taken = InstrTaken & r_valid;

    fetch_pc #(.ADDR_W(ADDR_W), .PC_RESET(PC_RESET)) u_pc (
        .Clock    (Clock),
        .Clear    (Clear),
        .i_load   (w_pc_load),
        .i_inc    (w_pc_inc),
        .i_target (w_pc_target),
        .o_pc     (w_pc)
    );

    // Next-state, request and instruction-register decisions
    always_comb begin
        w_state_nx   = r_state;
        w_mem_req_nx = r_mem_req;
        w_ir_nx      = r_ir;
        w_valid_nx   = r_valid;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_target  = BranchTarget;
`ifdef FETCH_PREFETCH_EN
        w_buf_nx       = r_buf;
        w_buf_valid_nx = r_buf_valid;
        w_tgt_nx       = r_tgt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_state_nx   = ST_FETCH;
                w_mem_req_nx = 1'b1;
            end
            ST_FETCH: begin
                if (w_ack) begin
                    w_ir_nx    = MemData;
                    w_pc_inc   = 1'b1;
                    w_valid_nx = 1'b1;
                    w_state_nx = ST_HOLD;
`ifdef FETCH_PREFETCH_EN
                    w_mem_req_nx = 1'b1;
`else
                    w_mem_req_nx = 1'b0;
`endif
                end else begin
                    w_mem_req_nx = 1'b1;
                end
            end
            ST_HOLD: begin
`ifdef FETCH_PREFETCH_EN
                // An outstanding prefetch must complete before the redirect address goes out
                if (w_taken && Branch) begin
                    w_buf_valid_nx = 1'b0;
                    w_valid_nx     = 1'b0;
                    if (r_mem_req && !MemAck) begin
                        w_tgt_nx   = BranchTarget;
                        w_state_nx = ST_FLUSH;
                    end else begin
                        w_pc_load    = 1'b1;
                        w_mem_req_nx = 1'b1;
                        w_state_nx   = ST_FETCH;
                    end
                end else if (w_taken) begin
                    if (r_buf_valid) begin
                        w_ir_nx        = r_buf;
                        w_buf_valid_nx = 1'b0;
                        w_mem_req_nx   = 1'b1;
                    end else if (w_ack) begin
                        w_ir_nx  = MemData;
                        w_pc_inc = 1'b1;
                    end else begin
                        w_valid_nx   = 1'b0;
                        w_mem_req_nx = 1'b1;
                        w_state_nx   = ST_FETCH;
                    end
                end else if (w_ack) begin
                    w_buf_nx       = MemData;
                    w_buf_valid_nx = 1'b1;
                    w_pc_inc       = 1'b1;
                    w_mem_req_nx   = 1'b0;
                end else begin
                    w_mem_req_nx = ~r_buf_valid;
                end
`else
                if (w_taken) begin
                    w_valid_nx   = 1'b0;
                    w_mem_req_nx = 1'b1;
                    w_pc_load    = Branch;
                    w_state_nx   = ST_FETCH;
                end else begin
                    w_mem_req_nx = 1'b0;
                end
`endif
            end
`ifdef FETCH_PREFETCH_EN
            ST_FLUSH: begin
                if (w_ack) begin
                    w_pc_load   = 1'b1;
                    w_pc_target = r_tgt;
                    w_state_nx  = ST_FETCH;
                end else begin
                    w_mem_req_nx = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nx   = ST_IDLE;
                w_mem_req_nx = 1'b0;
                w_valid_nx   = 1'b0;
            end
        endcase
    end

    // State and output registers; Clear forces reset values immediately
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_ir      <= {INSTR_W{1'b0}};
            r_valid   <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            r_buf       <= {INSTR_W{1'b0}};
            r_buf_valid <= 1'b0;
            r_tgt       <= PC_RESET;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_mem_req <= w_mem_req_nx;
            r_ir      <= w_ir_nx;
            r_valid   <= w_valid_nx;
`ifdef FETCH_PREFETCH_EN
            r_buf       <= w_buf_nx;
            r_buf_valid <= w_buf_valid_nx;
            r_tgt       <= w_tgt_nx;
`endif
        end
    end

    assign MemReq     = r_mem_req;
    assign MemAddr    = w_pc;
    assign PC         = w_pc;
    assign InstrValid = r_valid;
    assign OPCODE     = r_ir[INSTR_W-1 -: OPCODE_W];
    assign Operand    = r_ir[INSTR_W-4:0];

endmodule
